// File: rtl/vote_pkg.sv
// Shared definitions for the vote_tally block.
//   state_t   : control states of the tally FSM
//   sel_width : candidate-index width that stays >= 1 even for tiny counts
package vote_pkg;

    typedef enum logic [1:0] {
        ARMED        = 2'd0,
        WAIT_RELEASE = 2'd1,
        RESULT       = 2'd2
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vote_leader_sel.sv
// Argmax over NUM_CAND packed counters, lowest index wins on ties.
// Ports:
//   counts : NUM_CAND*CNT_W packed counter values, candidate i at [i*CNT_W +: CNT_W]
//   leader : index of the largest counter (0 when all counters are equal)
module vote_leader_sel
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int SEL_W    = sel_width(NUM_CAND)
) (
    input  logic [NUM_CAND*CNT_W-1:0] counts,
    output logic [SEL_W-1:0]          leader
);

    logic [CNT_W-1:0] best;

    // Linear chain; a strict '>' keeps the earlier (lower) index on ties.
    always_comb begin
        best   = counts[CNT_W-1:0];
        leader = '0;
        for (int unsigned i = 1; i < NUM_CAND; i++) begin
            if (counts[i*CNT_W +: CNT_W] > best) begin
                best   = counts[i*CNT_W +: CNT_W];
                leader = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Saturating per-candidate vote counter with single-choice enforcement and
// result-mode gated readout.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   mode          : 0 = voting, 1 = result
//   vote_valid    : one level bit per candidate button
//   rd_sel        : candidate index for readout
//   rd_count      : registered count of rd_sel (0 outside result mode / out of range)
//   total_votes   : registered sum of accepted votes (0 outside result mode)
//   leader_idx    : registered argmax of the counters, lowest index on tie
//   leader_valid  : result mode and total non-zero
//   vote_accept   : one-cycle pulse, vote counted
//   vote_reject   : one-cycle pulse, press ignored
//   sat_flag      : sticky per-candidate saturation flags
module vote_tally
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int SEL_W    = sel_width(NUM_CAND),
    parameter int TOT_W    = CNT_W + SEL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] vote_valid,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [CNT_W-1:0]    rd_count,
    output logic [TOT_W-1:0]    total_votes,
    output logic [SEL_W-1:0]    leader_idx,
    output logic                leader_valid,
    output logic                vote_accept,
    output logic                vote_reject,
    output logic [NUM_CAND-1:0] sat_flag
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);

    state_t                    state, state_next;
    logic [CNT_W-1:0]          count [NUM_CAND];
    logic [TOT_W-1:0]          total;
    logic [NUM_CAND*CNT_W-1:0] count_flat;
    logic [SEL_W-1:0]          leader_comb;
    logic [SEL_W-1:0]          hit_idx;
    logic [CNT_W-1:0]          rd_val;
    logic                      press_eval;
    logic                      hit_sat;
    logic                      accept_now;
    logic                      reject_now;

    // Only meaningful when exactly one button is pressed.
    always_comb begin
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (vote_valid[i]) hit_idx = SEL_W'(i);
        end
    end

    assign press_eval = (state == ARMED) && !mode && (vote_valid != '0);
    assign hit_sat    = (count[hit_idx] == CNT_MAX);
    assign accept_now = press_eval && $onehot(vote_valid) && !hit_sat;
    assign reject_now = press_eval && !accept_now;

    always_comb begin
        count_flat = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            count_flat[i*CNT_W +: CNT_W] = count[i];
        end
    end

    always_comb begin
        rd_val = '0;
        if (32'(rd_sel) < 32'(NUM_CAND)) rd_val = count[rd_sel];
    end

    vote_leader_sel #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .SEL_W    (SEL_W)
    ) u_leader (
        .counts (count_flat),
        .leader (leader_comb)
    );

    // Leaving RESULT goes through WAIT_RELEASE so buttons held across the
    // mode change are never counted.
    always_comb begin
        state_next = state;
        case (state)
            ARMED: begin
                if (mode)                    state_next = RESULT;
                else if (vote_valid != '0)   state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (mode)                    state_next = RESULT;
                else if (vote_valid == '0)   state_next = ARMED;
            end
            RESULT: begin
                if (!mode)                   state_next = WAIT_RELEASE;
            end
            default:                         state_next = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ARMED;
        else       state <= state_next;
    end

    // Result outputs are gated by the mode sampled at the same edge, so they
    // unmask/mask exactly one cycle after mode changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) count[i] <= '0;
            total        <= '0;
            sat_flag     <= '0;
            vote_accept  <= 1'b0;
            vote_reject  <= 1'b0;
            rd_count     <= '0;
            total_votes  <= '0;
            leader_idx   <= '0;
            leader_valid <= 1'b0;
        end else begin
            vote_accept <= accept_now;
            vote_reject <= reject_now;
            if (accept_now) begin
                count[hit_idx] <= count[hit_idx] + CNT_W'(1);
                total          <= total + TOT_W'(1);
                if (count[hit_idx] == CNT_NEAR) sat_flag[hit_idx] <= 1'b1;
            end
            rd_count     <= mode ? rd_val : '0;
            total_votes  <= mode ? total : '0;
            leader_valid <= mode && (total != '0);
            leader_idx   <= leader_comb;
        end
    end

endmodule
